uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, is the clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, is the line bit rate in bit/s.
REQ-003 Parameter DATA_WIDTH, default 8, is the number of data bits per frame.
REQ-004 Port clk, input, 1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port rx_i, input, 1: asynchronous serial line; idles high.
REQ-007 Port data_o, output, DATA_WIDTH: last correctly framed word, LSB received first.
REQ-008 Port valid_o, output, 1: one-cycle pulse when data_o is updated with a new word.
REQ-009 Port frame_err_o, output, 1: one-cycle pulse when a stop bit is sampled low.
REQ-010 Port rx_ready_o, output, 1: high while the receiver is in IDLE; it drives a transmitter's rx_ready_i.

Function
REQ-011 BIT_MAX SHALL equal CLK_FREQ/BAUD_RATE (integer division, truncated) and HALF SHALL equal BIT_MAX/2; BIT_MAX < 4 SHALL be a fatal elaboration error.
REQ-012 rx_i SHALL pass through a two-flop synchronizer; rx_s is its output, and rx_s_d is rx_s delayed one cycle.
REQ-013 The bit counter SHALL be $clog2(BIT_MAX) bits wide, SHALL clear on every state change, and SHALL otherwise increment each cycle.
REQ-014 The FSM SHALL have exactly four states: IDLE, START, DATA, and STOP.
REQ-015 IDLE: the FSM SHALL go to START only on a falling edge (rx_s==0 and rx_s_d==1); a line held low SHALL NOT trigger a start.
REQ-016 START: at counter==HALF-1, the FSM SHALL go to DATA if rx_s==0; otherwise it SHALL return to IDLE with no output pulse (glitch rejection).
REQ-017 DATA: at each counter==BIT_MAX-1, rx_s SHALL be shifted into the MSB of the shift register (right shift) and the bit index SHALL increment; after the DATA_WIDTH-th sample, the FSM SHALL go to STOP.
REQ-018 STOP: at counter==BIT_MAX-1, the FSM SHALL sample rx_s and go to IDLE.
REQ-019 If the stop sample is 1, data_o SHALL load the shift register and valid_o SHALL be asserted for exactly the next cycle.
REQ-020 If the stop sample is 0, frame_err_o SHALL be asserted for exactly the next cycle, data_o SHALL hold its old value, and valid_o SHALL stay low.
REQ-021 valid_o and frame_err_o SHALL never be high in the same cycle.
REQ-022 Latency: if the IDLE-to-START edge is E0, the STOP-to-IDLE edge SHALL be E0+HALF+(DATA_WIDTH+1)*BIT_MAX, and the pulse SHALL be high in the cycle after that edge.
REQ-023 Back-to-back frames with no idle gap beyond the stop bit SHALL be received without loss, because IDLE is re-entered at mid-stop-bit.
REQ-024 rx_ready_o SHALL be decoded from the state register: 1 in IDLE, 0 in every other state.
REQ-025 An illegal state encoding SHALL return the FSM to IDLE on the next edge.

Reset
REQ-026 While rst is high at a clock edge, the following SHALL take effect: state=IDLE, counter=0, bit index=0, shift register=0, synchronizer flops and rx_s_d=1.
REQ-027 While rst is high at a clock edge, outputs SHALL be: data_o=0, valid_o=0, frame_err_o=0, rx_ready_o=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no pulse.
REQ-029 After reset deasserts, the next frame SHALL be received only from a fresh falling edge.

Verification
REQ-030 The bench SHALL use CLK_FREQ=16, BAUD_RATE=1, DATA_WIDTH=8, giving BIT_MAX=16 and HALF=8.
REQ-031 Frame 0xA5 with a good stop bit -> valid_o pulses once, data_o=0xA5, and the pulse occurs 152 cycles after the E0 edge.
REQ-032 Frame 0x3C with the stop bit driven low -> frame_err_o pulses once, valid_o=0, data_o keeps its previous value 0xA5.
REQ-033 A 4-cycle low glitch on an idle line -> the FSM returns to IDLE, no pulse occurs, and rx_ready_o is high again within 11 cycles of the glitch start.
REQ-034 Frames 0x00 then 0xFF sent back-to-back with exactly one stop bit -> two valid_o pulses, 160 cycles apart, with data 0x00 then 0xFF.
REQ-035 Line held low for 40 bit times (break) -> exactly one frame_err_o pulse; no further activity until the line returns high and falls again.
REQ-036 rst asserted at data bit 4 of frame 0x5A -> no pulse, all outputs at reset values; a following frame 0x81 -> valid_o pulses with data_o=0x81.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchronized line, mid-bit sampling, glitch
// rejection on the start bit, and one-cycle valid / framing-error pulses.
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  frame_err_o,
  output logic                  rx_ready_o
);

  localparam int unsigned BIT_MAX = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF    = BIT_MAX / 2;
  localparam int unsigned CNT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam int unsigned IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(BIT_MAX - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  generate
    if (BIT_MAX < 4) begin : g_bad_baud
      $fatal(1, "uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  sync_q;
  logic                  rx_s;
  logic                  rx_s_d;

  // Metastability synchronizer plus one extra stage for falling-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      sync_q <= rx_i;
      rx_s   <= sync_q;
      rx_s_d <= rx_s;
    end
  end

  // Receive FSM with registered data and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      cnt         <= cnt + 1'b1;
      case (state)
        IDLE: begin
          if (!rx_s && rx_s_d) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // Line must still be low at mid start bit, otherwise it was a glitch.
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == BIT_M1) begin
            cnt   <= '0;
            shreg <= DATA_WIDTH'({rx_s, shreg} >> 1);
            if (bit_idx == LAST_IDX) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch the next start edge.
          if (cnt == BIT_M1) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              data_o  <= shreg;
              valid_o <= 1'b1;
            end else begin
              frame_err_o <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign rx_ready_o = (state == IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ  = 16;
  localparam int unsigned BAUD_RATE = 1;
  localparam int unsigned DW        = 8;
  localparam int unsigned BIT_MAX   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF      = BIT_MAX / 2;
  // Two synchronizer flops plus the edge-detect compare before START.
  localparam int unsigned SYNC_LAT  = 3;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int unsigned cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_i = 1'b1;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          frame_err_o;
  logic          rx_ready_o;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_data = 8'h00;
  bit          both_seen = 1'b0;
  ev_t         ev_q[$];

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_WIDTH(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .frame_err_o(frame_err_o),
    .rx_ready_o (rx_ready_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse away from the active edge.
  always @(negedge clk) begin
    if (!rst && (valid_o || frame_err_o)) begin
      ev_q.push_back('{is_err: frame_err_o, data: data_o, cyc: cyc});
      if (valid_o && frame_err_o) both_seen = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    tick(BIT_MAX);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  function automatic ev_t first_ev(input int idx);
    ev_t e;
    e = '{is_err: 1'b1, data: 8'hEE, cyc: 0};
    if (idx < ev_q.size()) e = ev_q[idx];
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    rx_i = 1'b1;
    tick(3);
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%0h exp=00", data_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%0b exp=0", frame_err_o); end
    checks++; if (rx_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", rx_ready_o); end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_latency();
    int unsigned c0;
    ev_t e;
    ev_q.delete();
    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    tick(20);
    e = first_ev(0);
    checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL lat_count got=%0d exp=1", ev_q.size()); end
    checks++; if (e.is_err !== 1'b0) begin errors++; $display("FAIL lat_kind got=%0b exp=0", e.is_err); end
    checks++; if (e.data !== 8'hA5) begin errors++; $display("FAIL lat_data got=%0h exp=a5", e.data); end
    checks++;
    if (e.cyc - c0 !== SYNC_LAT + HALF + (DW + 1) * BIT_MAX) begin
      errors++;
      $display("FAIL lat_cycles got=%0d exp=%0d", e.cyc - c0, SYNC_LAT + HALF + (DW + 1) * BIT_MAX);
    end
    exp_data = 8'hA5;
  endtask

  task automatic test_frame_err();
    ev_t e;
    ev_q.delete();
    send_frame(8'h3C, 1'b0);
    rx_i = 1'b1;
    tick(2 * BIT_MAX);
    e = first_ev(0);
    checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", ev_q.size()); end
    checks++; if (e.is_err !== 1'b1) begin errors++; $display("FAIL ferr_kind got=%0b exp=1", e.is_err); end
    checks++; if (data_o !== exp_data) begin errors++; $display("FAIL ferr_hold got=%0h exp=%0h", data_o, exp_data); end
  endtask

  task automatic test_glitch();
    bit saw_low;
    int back;
    saw_low = 1'b0;
    back = 0;
    ev_q.delete();
    rx_i = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      if (k == 4) rx_i = 1'b1;
      if (!rx_ready_o) saw_low = 1'b1;
      else if (saw_low && back == 0) back = k;
    end
    checks++; if (saw_low !== 1'b1) begin errors++; $display("FAIL glitch_start got=%0b exp=1", saw_low); end
    checks++;
    if (back == 0 || back > 11) begin errors++; $display("FAIL glitch_recover got=%0d exp<=11", back); end
    tick(12 * BIT_MAX);
    checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL glitch_pulse got=%0d exp=0", ev_q.size()); end
  endtask

  task automatic test_back_to_back();
    ev_t e0, e1;
    ev_q.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(20);
    e0 = first_ev(0);
    e1 = first_ev(1);
    checks++; if (ev_q.size() !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", ev_q.size()); end
    checks++;
    if (e0.is_err !== 1'b0 || e0.data !== 8'h00) begin
      errors++; $display("FAIL b2b_first got=%0b/%0h exp=0/00", e0.is_err, e0.data);
    end
    checks++;
    if (e1.is_err !== 1'b0 || e1.data !== 8'hFF) begin
      errors++; $display("FAIL b2b_second got=%0b/%0h exp=0/ff", e1.is_err, e1.data);
    end
    checks++;
    if (e1.cyc - e0.cyc !== (DW + 2) * BIT_MAX) begin
      errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", e1.cyc - e0.cyc, (DW + 2) * BIT_MAX);
    end
    exp_data = 8'hFF;
  endtask

  task automatic test_break();
    ev_t e;
    ev_q.delete();
    rx_i = 1'b0;
    tick(40 * BIT_MAX);
    e = first_ev(0);
    checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL break_count got=%0d exp=1", ev_q.size()); end
    checks++; if (e.is_err !== 1'b1) begin errors++; $display("FAIL break_kind got=%0b exp=1", e.is_err); end
    checks++; if (rx_ready_o !== 1'b1) begin errors++; $display("FAIL break_ready got=%0b exp=1", rx_ready_o); end
    rx_i = 1'b1;
    tick(3 * BIT_MAX);
    checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL break_quiet got=%0d exp=1", ev_q.size()); end
    checks++; if (data_o !== exp_data) begin errors++; $display("FAIL break_hold got=%0h exp=%0h", data_o, exp_data); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    ev_t e;
    d = 8'h5A;
    ev_q.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_i = d[4];
    tick(HALF);
    rst = 1'b1;
    tick(1);
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%0h exp=00", data_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%0b exp=0", valid_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL rstmid_ferr got=%0b exp=0", frame_err_o); end
    checks++; if (rx_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%0b exp=1", rx_ready_o); end
    tick(2);
    rst = 1'b0;
    rx_i = 1'b1;
    exp_data = 8'h00;
    tick(12 * BIT_MAX);
    checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL rstmid_quiet got=%0d exp=0", ev_q.size()); end
    send_frame(8'h81, 1'b1);
    tick(20);
    e = first_ev(0);
    checks++;
    if (ev_q.size() !== 1 || e.is_err !== 1'b0 || e.data !== 8'h81) begin
      errors++; $display("FAIL rstmid_next got=%0d/%0b/%0h exp=1/0/81", ev_q.size(), e.is_err, e.data);
    end
    exp_data = 8'h81;
  endtask

  task automatic test_random();
    ev_t exp_q[$];
    ev_t e;
    logic [7:0] d;
    logic stop;
    int gap;
    ev_q.delete();
    for (int f = 0; f < 8; f++) begin
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      gap = stop ? $urandom_range(0, 20) : $urandom_range(1, 20);
      send_frame(d, stop);
      if (stop) exp_data = d;
      exp_q.push_back('{is_err: !stop, data: exp_data, cyc: 0});
      rx_i = 1'b1;
      if (gap > 0) tick(gap);
    end
    tick(20);
    checks++;
    if (ev_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count got=%0d exp=%0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      e = first_ev(i);
      checks++;
      if (e.is_err !== exp_q[i].is_err || e.data !== exp_q[i].data) begin
        errors++;
        $display("FAIL rand_frame%0d got=%0b/%0h exp=%0b/%0h", i, e.is_err, e.data, exp_q[i].is_err, exp_q[i].data);
      end
    end
    checks++; if (data_o !== exp_data) begin errors++; $display("FAIL rand_data got=%0h exp=%0h", data_o, exp_data); end
  endtask

  task automatic test_exclusive_pulses();
    checks++;
    if (both_seen !== 1'b0) begin errors++; $display("FAIL pulse_exclusive got=%0b exp=0", both_seen); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_latency();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_break();
    test_reset_mid_frame();
    test_random();
    test_exclusive_pulses();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
